// File: rtl/griffin_pkg.sv
// Shared BN254 scalar-field definitions for the Griffin datapath blocks.
// This package is the single place that defines the field modulus p.
package griffin_pkg;

    localparam int FIELD_W = 254;

    typedef logic [FIELD_W-1:0] felem_t;

    localparam felem_t PRIME_MODULUS =
        254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

    // Accumulator control states; out_valid is high exactly in ST_HOLD.
    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

endpackage

// File: rtl/mod_add_254.sv
// Combinational a + b mod p for operands already reduced below p.
// Because both inputs are < p, one conditional subtraction of p always gives a reduced result.
module mod_add_254
    import griffin_pkg::*;
(
    input  logic [FIELD_W-1:0] i_a,
    input  logic [FIELD_W-1:0] i_b,
    output logic [FIELD_W-1:0] o_sum
);

    logic [FIELD_W:0] w_sum_ext;
    logic [FIELD_W:0] w_p_ext;
    logic             w_ge_p;

    assign w_p_ext   = {1'b0, PRIME_MODULUS};
    assign w_sum_ext = {1'b0, i_a} + {1'b0, i_b};
    assign w_ge_p    = (w_sum_ext >= w_p_ext);
    assign o_sum     = w_ge_p ? FIELD_W'(w_sum_ext - w_p_ext) : w_sum_ext[FIELD_W-1:0];

endmodule

// File: rtl/griffin_mod_acc_254.sv
// Streaming per-group modular accumulator with a one-entry output register.
//   state    | meaning
//   ST_ACCUM | output register empty; beats accumulate into acc
//   ST_HOLD  | out_data/out_count hold a finished group sum (out_valid = 1)
module griffin_mod_acc_254
    import griffin_pkg::*;
#(
    parameter int WIDTH = FIELD_W,
    parameter int CNT_W = 8
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count
);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_out_data;
    logic [CNT_W-1:0] r_out_count;

    logic [WIDTH-1:0] w_sum;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_accept;
    logic             w_out_fire;

    mod_add_254 u_mod_add (
        .i_a   (r_acc),
        .i_b   (in_data),
        .o_sum (w_sum)
    );

    // A full output register can still take a beat if it is being drained this cycle.
    assign out_valid  = (r_state == ST_HOLD);
    assign in_ready   = !out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_cnt_inc  = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_count <= '0;
        end else begin
            if (w_accept && in_last) begin
                r_out_data  <= w_sum;
                r_out_count <= w_cnt_inc;
                r_acc       <= '0;
                r_cnt       <= '0;
            end else if (w_accept) begin
                r_acc <= w_sum;
                r_cnt <= w_cnt_inc;
            end

            // A new closing beat wins over a drain so the next sum follows with no bubble.
            if (w_accept && in_last) begin
                r_state <= ST_HOLD;
            end else if (w_out_fire) begin
                r_state <= ST_ACCUM;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_count = r_out_count;

endmodule

// File: doc/griffin_mod_acc_254.md
# griffin_mod_acc_254

Streaming modular accumulator for the BN254 scalar field, downstream of the small-constant field multiplier in the Griffin linear layer. It consumes a stream of reduced 254-bit products and sums each group mod p; a group ends on a beat with `in_last`. It emits one reduced sum per group over a valid/ready handshake, with a single-entry output register for backpressure.

## Interface
- `WIDTH`, 254: field element width.
- `CNT_W`, 8: width of the per-group term counter.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: input beat valid.
- `in_ready` output 1: block accepts a beat this cycle.
- `in_data` input WIDTH: field element. Caller guarantees `in_data < p`.
- `in_last` input 1: the beat closes the current group.
- `out_valid` output 1: `out_data` holds a completed group sum.
- `out_ready` input 1: consumer takes `out_data`.
- `out_data` output WIDTH: group sum mod p, always `< p`.
- `out_count` output CNT_W: number of terms in the emitted group, saturating at 2^CNT_W−1.

## Operation
- Accept occurs when `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. The block stalls only while the output register is full and not being drained.
- Accumulator `acc` (WIDTH bits) and term counter `cnt` are internal.
- Modular add on accept:
  - `s = acc + in_data`, computed at WIDTH+1 bits.
  - `r = (s >= p) ? s − p : s`.
  - One conditional subtraction suffices because both operands are `< p`.
- Accept with `in_last = 0`:
  - `acc <= r`.
  - `cnt <= cnt + 1`, saturating.
- Accept with `in_last = 1`:
  - `out_data <= r`.
  - `out_count <= cnt + 1`, saturating.
  - `out_valid <= 1`.
  - `acc <= 0`, `cnt <= 0`.
- Output handshake when `out_valid && out_ready`: `out_valid <= 0`, unless a new `in_last` accept happens in the same cycle, in which case `out_valid` stays 1 and `out_data` loads the new sum.
- A single-beat group (`in_last` on the first beat) outputs `in_data` unchanged, with count 1.
- States:
  - ACCUM: `out_valid = 0`.
  - HOLD: `out_valid = 1`.
  - ACCUM→HOLD on `in_last` accept.
  - HOLD→ACCUM on output handshake with no simultaneous `in_last` accept.
  - In HOLD with `out_ready = 1`, non-last beats keep accumulating.
- Reset (`rst_n = 0` at a clock edge):
  - `acc`, `cnt`, `out_data`, `out_count`, `out_valid` all go to 0.
  - Any partial group or unsent result is discarded.
  - `in_ready` is 1 after reset.

## Timing
- Latency: `out_valid` rises on the edge that accepts the `in_last` beat, so the sum is visible the cycle after that accept.
- Throughput: one beat per cycle, sustained, including back-to-back single-beat groups while `out_ready = 1`.
- `out_data` and `out_count` are stable while `out_valid && !out_ready`.
- Combinational paths: `out_ready` → `in_ready` only. There is no path from `in_data` to any output.
- Critical path: 255-bit add, then 255-bit compare/subtract. The block does not pipeline this path internally.

## Structure
- Shared package `griffin_pkg`:
  - `PRIME_MODULUS = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001`.
  - `FIELD_W = 254`.
  - `typedef logic [FIELD_W-1:0] felem_t`.
  - This is the single source of p for the multiplier and the accumulator.
- Sub-module `mod_add_254`: combinational `a + b mod p` with inputs `< p`. It is reused by the Griffin linear and round-constant stages.

## Test plan
- Single beat 5 with `in_last`, `out_ready = 1` → `out_data = 5`, `out_count = 1`, `out_valid` high for exactly one cycle.
- Beats p−1, then 2 with last → `out_data = 1`, `out_count = 2`. Covers the wrap-around subtract.
- Beats p−1, p−1, p−1 with the third as last → `out_data = p−3`, `out_count = 3`.
- Backpressure:
  - Group {3, 4 last} with `out_ready` held low for 4 cycles.
  - Required: `out_data = 7` held, `in_ready = 0` while stalled.
  - Then `out_ready = 1` with a simultaneous new beat 9 last → next `out_data = 9` with no bubble.
- Reset mid-operation:
  - Accept 7 (not last), assert `rst_n = 0` for one cycle, then accept 3 last.
  - Required: `out_data = 3`, `out_count = 1`.
- Random streams of 1–20 terms per group, all values `< p`, random `out_ready` → every output matches a reference model (sum mod p), with no lost or duplicated groups.
